envelope_peak_picker: RTL and testbench

Downstream consumer of the wavelet envelogram stream (normalized, decimated, Q2.29, non-negative).
- Finds local maxima above an amplitude threshold, enforcing a refractory gap between reported peaks.
- Emits {sample index, amplitude} records on an AXI-Stream master through a small output FIFO.
- These records are the S1/S2 candidate list used by the heart-sound segmentation logic.

---
 rtl/hss_pkg.sv | 21 ++
 rtl/peak_fifo.sv | 66 ++++++
 rtl/envelope_peak_picker.sv | 145 ++++++++++++++
 tb/tb_envelope_peak_picker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hss_pkg.sv
// hss_pkg: definitions shared by the heart-sound segmentation pipeline.
//   - state_t            : peak-picker FSM state encoding
//   - Q_ONE              : 1.0 in Q2.29
//   - DEFAULT_THRESHOLD  : 0.25 in Q2.29, the default peak amplitude floor
//   - REC_AMP_LSB        : peak records are {index, amplitude}; the amplitude
//                          starts at this bit and the index sits directly above it
package hss_pkg;

    typedef enum logic [1:0] {
        ST_WARM0,
        ST_WARM1,
        ST_SEARCH,
        ST_HOLDOFF
    } state_t;

    localparam logic [31:0] Q_ONE             = 32'h2000_0000;
    localparam logic [31:0] DEFAULT_THRESHOLD = 32'h0800_0000;

    localparam int unsigned REC_AMP_LSB = 0;

endpackage

// File: rtl/peak_fifo.sv
// peak_fifo: synchronous FIFO, asynchronous active-high reset.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is dropped and o_drop pulses for that cycle.
// Ports:
//   i_clk, i_rst      clock, async active-high reset (flushes the FIFO)
//   i_push, i_data    write request and data
//   i_pop             read request (ignored while empty)
//   o_data            head entry, 0 while empty
//   o_valid           FIFO not empty
//   o_full            FIFO full
//   o_drop            push rejected this cycle (full, no simultaneous pop)
module peak_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full,
    output logic             o_drop
);

    // DEPTH must be a power of two, at least 2
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    // Pointers carry one extra wrap bit to tell full from empty
    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    assign o_valid = !w_empty;
    assign o_full  = w_full;
    assign o_drop  = i_push && w_full && !w_pop;
    assign o_data  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage needs no reset; o_data is masked while empty.
    // When full, the slot written on a simultaneous push/pop is the one being read out.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/envelope_peak_picker.sv
// envelope_peak_picker: finds local maxima above a threshold in the
// normalized envelogram stream and emits {index, amplitude} records, with a
// refractory gap between reported peaks.
// Build option: define ADAPTIVE_THR_EN to raise the threshold to a quarter of
// the last detected peak amplitude when that is larger.
// Ports:
//   aclk, areset                 clock, async active-high reset
//   s_axis_data_t{data,valid}    envelogram samples (Q2.29, signed)
//   s_axis_data_tready           1 except while areset
//   m_axis_peak_t{data,valid}    peak records {index, amplitude}
//   m_axis_peak_tready           record accept
//   peak_count                   detected peaks, including dropped ones (wraps)
//   overflow                     sticky: a record was dropped on a full FIFO
module envelope_peak_picker
    import hss_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      IDX_W      = 16,
    parameter logic [WIDTH-1:0] THRESHOLD  = WIDTH'(DEFAULT_THRESHOLD),
    parameter int unsigned      REFRACTORY = 40,
    parameter int unsigned      FIFO_DEPTH = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [WIDTH-1:0]       s_axis_data_tdata,
    input  logic                   s_axis_data_tvalid,
    output logic                   s_axis_data_tready,
    output logic [IDX_W+WIDTH-1:0] m_axis_peak_tdata,
    output logic                   m_axis_peak_tvalid,
    input  logic                   m_axis_peak_tready,
    output logic [IDX_W-1:0]       peak_count,
    output logic                   overflow
);

    localparam logic signed [WIDTH-1:0] THR_S = THRESHOLD;
    localparam logic [IDX_W-1:0]        REFR  = IDX_W'(REFRACTORY);

    state_t                   r_state;
    logic signed [WIDTH-1:0]  r_p1;
    logic signed [WIDTH-1:0]  r_p2;
    logic [IDX_W-1:0]         r_idx;       // index the next accepted sample gets
    logic [IDX_W-1:0]         r_last_idx;  // index of the last reported peak
    logic [IDX_W-1:0]         r_count;
    logic                     r_overflow;

    logic                     w_accept;
    logic signed [WIDTH-1:0]  w_c;
    logic signed [WIDTH-1:0]  w_thr;
    logic [IDX_W-1:0]         w_cand_idx;
    logic                     w_is_peak;
    logic                     w_gap_ok;
    logic                     w_hit;
    logic [IDX_W+WIDTH-1:0]   w_rec;
    logic                     w_pop;
    logic                     w_full;
    logic                     w_drop;

    assign s_axis_data_tready = !areset;
    assign w_accept           = s_axis_data_tvalid && s_axis_data_tready;
    assign w_c                = $signed(s_axis_data_tdata);

`ifdef ADAPTIVE_THR_EN
    logic signed [WIDTH-1:0] r_last_amp;
    logic signed [WIDTH-1:0] w_amp_q;

    assign w_amp_q = r_last_amp >>> 2;
    assign w_thr   = (w_amp_q > THR_S) ? w_amp_q : THR_S;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)     r_last_amp <= '0;
        else if (w_hit) r_last_amp <= r_p1;
    end
`else
    assign w_thr = THR_S;
`endif

    // The candidate is the previously accepted sample (p1), judged against its
    // predecessor (p2) and the sample being accepted now (c). Strict > on the
    // left makes only the first sample of a plateau qualify.
    assign w_cand_idx = r_idx - 1'b1;
    assign w_is_peak  = (r_p1 > r_p2) && (r_p1 >= w_c) && (r_p1 >= w_thr);
    assign w_gap_ok   = (w_cand_idx - r_last_idx) > REFR;

    // The candidate that first clears the refractory gap is evaluated on the
    // same accept that ends the holdoff.
    assign w_hit = w_accept && w_is_peak &&
                   ((r_state == ST_SEARCH) || ((r_state == ST_HOLDOFF) && w_gap_ok));

    always_comb begin
        w_rec = '0;
        w_rec[REC_AMP_LSB +: WIDTH]         = r_p1;
        w_rec[REC_AMP_LSB + WIDTH +: IDX_W] = w_cand_idx;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state    <= ST_WARM0;
            r_p1       <= '0;
            r_p2       <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_p2  <= r_p1;
                r_p1  <= w_c;
                r_idx <= r_idx + 1'b1;
                case (r_state)
                    ST_WARM0:   r_state <= ST_WARM1;
                    ST_WARM1:   r_state <= ST_SEARCH;
                    ST_SEARCH:  if (w_hit) r_state <= ST_HOLDOFF;
                    ST_HOLDOFF: if (w_gap_ok && !w_hit) r_state <= ST_SEARCH;
                    default:    r_state <= ST_WARM0;
                endcase
            end
            if (w_hit) begin
                r_last_idx <= w_cand_idx;
                r_count    <= r_count + 1'b1;
            end
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign w_pop = m_axis_peak_tvalid && m_axis_peak_tready;

    peak_fifo #(
        .WIDTH (IDX_W + WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_push  (w_hit),
        .i_data  (w_rec),
        .i_pop   (w_pop),
        .o_data  (m_axis_peak_tdata),
        .o_valid (m_axis_peak_tvalid),
        .o_full  (w_full),
        .o_drop  (w_drop)
    );

    assign peak_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_envelope_peak_picker.sv
module tb_envelope_peak_picker;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [47:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [15:0] peak_count;
    logic        overflow;

    always #5 aclk = ~aclk;

    envelope_peak_picker #(
        .WIDTH      (32),
        .IDX_W      (16),
        .THRESHOLD  (32'h0800_0000),
        .REFRACTORY (40),
        .FIFO_DEPTH (4)
    ) dut (
        .aclk               (aclk),
        .areset             (areset),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready),
        .m_axis_peak_tdata  (m_tdata),
        .m_axis_peak_tvalid (m_tvalid),
        .m_axis_peak_tready (m_tready),
        .peak_count         (peak_count),
        .overflow           (overflow)
    );

    logic [47:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned pk_idx[$];
    logic [31:0] pk_amp[$];

    function automatic logic [47:0] rec(input int unsigned idx, input logic [31:0] amp);
        logic [15:0] i16;
        i16 = idx[15:0];
        return {i16, amp};
    endfunction

    // Scoreboard: every handshake seen at the negedge completes on the next posedge
    always @(negedge aclk) begin
        if (!areset && m_tvalid && m_tready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $error("FAIL unexpected_record: got %h, expected none", m_tdata);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                assert (m_tdata === e) else begin
                    n_err++;
                    $error("FAIL record: got %h, expected %h", m_tdata, e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // All tasks start and end at posedge+1
    task automatic send(input logic [31:0] d, input int gap);
        s_tdata  = d;
        s_tvalid = 1'b1;
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge aclk); #1;
        end
    endtask

    task automatic stream(input int from, input int to, input int gap);
        logic [31:0] d;
        for (int i = from; i < to; i++) begin
            d = '0;
            foreach (pk_idx[k]) if (pk_idx[k] == i) d = pk_amp[k];
            send(d, gap);
        end
    endtask

    task automatic do_reset(input string tag);
        areset   = 1'b1;
        s_tvalid = 1'b0;
        #2;
        chk({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({tag, "_tdata"}, 64'(m_tdata), 64'd0);
        chk({tag, "_count"}, 64'(peak_count), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        areset   = 1'b0;
        m_tready = 1'b1;
        #1;
        chk({tag, "_s_tready_rel"}, 64'(s_tready), 64'd1);
        @(posedge aclk); #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge aclk); #1;
        end
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (3) begin
            @(posedge aclk); #1;
        end
        chk({tag, "_tvalid_idle"}, 64'(m_tvalid), 64'd0);
    endtask

    initial begin
        // Reset state
        #1;
        do_reset("reset");

        // Basic peak
        send(32'h0000_0000, 0);
        send(32'h0400_0000, 0);
        send(32'h1000_0000, 0);
        send(32'h0C00_0000, 0);
        exp_q.push_back(rec(2, 32'h1000_0000));
        send(32'h0000_0000, 0);
        wait_drain("basic");
        chk("basic_count", 64'(peak_count), 64'd1);

        // Threshold just below
        do_reset("rst_thr");
        send(32'h0000_0000, 0);
        send(32'h07FF_FFFF, 0);
        send(32'h0000_0000, 0);
        send(32'h0000_0000, 0);
        wait_drain("thr_low");
        chk("thr_low_count", 64'(peak_count), 64'd0);

        // Threshold exactly met
        do_reset("rst_thr2");
        send(32'h0000_0000, 0);
        send(32'h0800_0000, 0);
        exp_q.push_back(rec(1, 32'h0800_0000));
        send(32'h0000_0000, 0);
        wait_drain("thr_eq");
        chk("thr_eq_count", 64'(peak_count), 64'd1);

        // Plateau
        do_reset("rst_plat");
        send(32'h0000_0000, 0);
        send(32'h1000_0000, 0);
        send(32'h1000_0000, 0);
        exp_q.push_back(rec(1, 32'h1000_0000));
        send(32'h1000_0000, 0);
        send(32'h0000_0000, 0);
        wait_drain("plateau");
        chk("plateau_count", 64'(peak_count), 64'd1);

        // Refractory gap, continuous and with 3-cycle input gaps
        for (int g = 0; g <= 3; g += 3) begin
            do_reset("rst_ref40");
            pk_idx = '{5, 45};
            pk_amp = '{32'h1000_0000, 32'h1200_0000};
            exp_q.push_back(rec(5, 32'h1000_0000));
            stream(0, 60, g);
            wait_drain("ref40");
            chk("ref40_count", 64'(peak_count), 64'd1);

            do_reset("rst_ref41");
            pk_idx = '{5, 46};
            exp_q.push_back(rec(5, 32'h1000_0000));
            exp_q.push_back(rec(46, 32'h1200_0000));
            stream(0, 60, g);
            wait_drain("ref41");
            chk("ref41_count", 64'(peak_count), 64'd2);
        end

        // Backpressure: five peaks into a four-deep FIFO
        do_reset("rst_bp");
        m_tready = 1'b0;
        pk_idx = '{2, 50, 98, 146, 194};
        pk_amp = '{32'h1000_0000, 32'h1100_0000, 32'h1200_0000, 32'h1300_0000, 32'h1400_0000};
        stream(0, 200, 0);
        repeat (2) begin
            @(posedge aclk); #1;
        end
        chk("bp_count", 64'(peak_count), 64'd5);
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_tvalid", 64'(m_tvalid), 64'd1);
        chk("bp_head_stable", 64'(m_tdata), 64'(rec(2, 32'h1000_0000)));
        for (int k = 0; k < 4; k++) exp_q.push_back(rec(pk_idx[k], pk_amp[k]));
        m_tready = 1'b1;
        wait_drain("bp");

        // Push and pop in the same cycle while full
        do_reset("rst_pp");
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) exp_q.push_back(rec(pk_idx[k], pk_amp[k]));
        stream(0, 195, 0);
        chk("pp_full_count", 64'(peak_count), 64'd4);
        m_tready = 1'b1;
        stream(195, 200, 0);
        wait_drain("pp");
        chk("pp_count", 64'(peak_count), 64'd5);
        chk("pp_overflow", 64'(overflow), 64'd0);

        // Mid-run reset in HOLDOFF with two records pending
        do_reset("rst_mid");
        m_tready = 1'b0;
        pk_idx = '{2, 50};
        pk_amp = '{32'h1000_0000, 32'h1100_0000};
        stream(0, 56, 0);
        chk("mid_pending_count", 64'(peak_count), 64'd2);
        chk("mid_pending_tvalid", 64'(m_tvalid), 64'd1);
        do_reset("mid_reset");
        send(32'h0000_0000, 0);
        send(32'h0400_0000, 0);
        send(32'h1000_0000, 0);
        send(32'h0C00_0000, 0);
        exp_q.push_back(rec(2, 32'h1000_0000));
        send(32'h0000_0000, 0);
        wait_drain("mid_restart");
        chk("mid_restart_count", 64'(peak_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
